// File: rtl/dds_freq_counter_pkg.sv
// Shared DDS types: sample format, frequency-counter FSM states and width helpers.
package dds_pkg;
  localparam int SAMPLE_WIDTH = 18;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {COUNT, DRAIN, HOLD} cnt_state_e;

  function automatic int count_bits(input int window_bits, input int parallel_samples);
    return window_bits + $clog2(parallel_samples);
  endfunction

  function automatic int sum_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dds_freq_counter_if.sv
// Parallel-sample multichannel stream and plain AXI-stream word interfaces.
interface Axis_Parallel_If #(
  parameter int DWIDTH   = 72,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]             valid;
  logic [CHANNELS-1:0]             ready;
  logic [CHANNELS-1:0][DWIDTH-1:0] data;
  logic [CHANNELS-1:0]             ok;

  assign ok = valid & ready;

  modport master (output valid, data, input ready, ok);
  modport slave  (input valid, data, ok, output ready);
endinterface

interface Axis_If #(
  parameter int DWIDTH = 12
);
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;
  logic              ok;

  assign ok = valid & ready;

  modport master (output valid, data, input ready, ok);
  modport slave  (input valid, data, ok, output ready);
endinterface

// File: rtl/dds_freq_counter_zcd.sv
// Per-channel rising zero-crossing detector: registers the crossing vector of an
// accepted word and presents its popcount one cycle later.
module zero_cross_detect
  import dds_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 18,
  parameter int PARALLEL_SAMPLES = 4,
  localparam int CW              = sum_width(PARALLEL_SAMPLES)
)(
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     in_vld,
  input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] word,
  input  logic [SAMPLE_WIDTH-1:0]                  prev,
  input  logic                                     prev_valid,
  output logic [CW-1:0]                            cnt,
  output logic                                     cnt_vld
);
  logic [PARALLEL_SAMPLES-1:0] x_c, x_q;

  // Crossing = previous sign bit set, current sign bit clear; sample 0 looks at the last word.
  always_comb begin
    x_c    = '0;
    x_c[0] = prev_valid & prev[SAMPLE_WIDTH-1] & ~word[SAMPLE_WIDTH-1];
    for (int i = 1; i < PARALLEL_SAMPLES; i++)
      x_c[i] = word[(i-1)*SAMPLE_WIDTH + SAMPLE_WIDTH-1] & ~word[i*SAMPLE_WIDTH + SAMPLE_WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      cnt_vld <= 1'b0;
    end else begin
      x_q     <= in_vld ? x_c : '0;
      cnt_vld <= in_vld;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < PARALLEL_SAMPLES; i++)
      cnt = cnt + CW'(x_q[i]);
  end
endmodule

// File: rtl/dds_freq_counter.sv
// Multichannel zero-crossing frequency counter: counts rising crossings over a fixed
// window per channel, then presents all channel counts as one stream word.
module dds_freq_counter
  import dds_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 18,
  parameter int PARALLEL_SAMPLES = 4,
  parameter int CHANNELS         = 2,
  parameter int WINDOW_BITS      = 10,
  parameter int COUNT_BITS       = count_bits(WINDOW_BITS, PARALLEL_SAMPLES)
)(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  Axis_Parallel_If.slave  data_in,
  Axis_If.master          count_out
);
  localparam int DW  = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam int PCW = sum_width(PARALLEL_SAMPLES);
  localparam logic [WINDOW_BITS:0] WLAST = (WINDOW_BITS+1)'((1 << WINDOW_BITS) - 1);
  localparam logic [WINDOW_BITS:0] WONE  = (WINDOW_BITS+1)'(1);

  cnt_state_e                            state;
  logic [CHANNELS-1:0]                   done, prev_valid, xvld;
  logic [CHANNELS-1:0][WINDOW_BITS:0]    wcnt;
  logic [CHANNELS-1:0][COUNT_BITS-1:0]   acc;
  logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0] prev;
  logic [CHANNELS-1:0][PCW-1:0]          xcnt;

  // reset_n in the term keeps ready low while reset is held, whatever enable does.
  assign data_in.ready = {CHANNELS{reset_n & enable & (state == COUNT)}} & ~done;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    zero_cross_detect #(
      .SAMPLE_WIDTH     (SAMPLE_WIDTH),
      .PARALLEL_SAMPLES (PARALLEL_SAMPLES)
    ) u_zcd (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_vld     (data_in.ok[c]),
      .word       (data_in.data[c]),
      .prev       (prev[c]),
      .prev_valid (prev_valid[c]),
      .cnt        (xcnt[c]),
      .cnt_vld    (xvld[c])
    );
  end

  // prev/prev_valid survive the handshake so crossings straddling windows still count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt       <= '0;
      acc        <= '0;
      done       <= '0;
      prev       <= '0;
      prev_valid <= '0;
    end else if (count_out.ok) begin
      wcnt <= '0;
      acc  <= '0;
      done <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (data_in.ok[c]) begin
          wcnt[c]       <= wcnt[c] + WONE;
          prev[c]       <= data_in.data[c][DW-1 -: SAMPLE_WIDTH];
          prev_valid[c] <= 1'b1;
          if (wcnt[c] == WLAST) done[c] <= 1'b1;
        end
        if (xvld[c]) acc[c] <= acc[c] + COUNT_BITS'(xcnt[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= COUNT;
      count_out.valid <= 1'b0;
      count_out.data  <= '0;
    end else begin
      case (state)
        COUNT: if (&done) state <= DRAIN;
        DRAIN: if (xvld == '0) begin
          state           <= HOLD;
          count_out.valid <= 1'b1;
          count_out.data  <= acc;
        end
        HOLD: if (count_out.ok) begin
          state           <= COUNT;
          count_out.valid <= 1'b0;
        end
        default: state <= COUNT;
      endcase
    end
  end
endmodule
